banco_registros_wb: RTL



---
 rtl/banco_registros_wb.sv | 82 ++++++++
 1 files changed

// File: rtl/banco_registros_wb.sv
// banco_registros_wb: write-back select, 32x32 register file with two asynchronous read ports
// and a committed-write counter. Define BANCO_BYPASS_WB_EN for same-cycle write-through reads.
module banco_registros_wb #(
  parameter int ANCHO = 32,
  parameter int NREG  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ANCHO-1:0] EnDatoMem,
  input  logic [ANCHO-1:0] EnDatoALU,
  input  logic [4:0]       EnDirWR,
  input  logic [1:0]       EnWB,
  input  logic [4:0]       EnRA1,
  input  logic [4:0]       EnRA2,
  output logic [ANCHO-1:0] SalRD1,
  output logic [ANCHO-1:0] SalRD2,
  output logic [ANCHO-1:0] SalDatoWB,
  output logic [31:0]      SalCuentaWB
);

  localparam int NPUERTOS = 2;

  logic [ANCHO-1:0] w_regs [NREG];
  logic             w_commit;
  logic [31:0]      r_cuenta;
  logic [4:0]       w_ra [NPUERTOS];
  logic [ANCHO-1:0] w_rd [NPUERTOS];

  assign SalDatoWB = EnWB[0] ? EnDatoMem : EnDatoALU;

  // Register 0 never commits; addresses beyond NREG are ignored when NREG is reduced.
  assign w_commit = EnWB[1] && (EnDirWR != 5'd0) && (int'(EnDirWR) < NREG);

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_reg
      if (gi == 0) begin : g_cero
        assign w_regs[gi] = '0;
      end else begin : g_fila
        logic [ANCHO-1:0] r_dato;
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            r_dato <= '0;
          end else if (w_commit && (int'(EnDirWR) == gi)) begin
            r_dato <= SalDatoWB;
          end
        end
        assign w_regs[gi] = r_dato;
      end
    end
  endgenerate

  assign w_ra[0] = EnRA1;
  assign w_ra[1] = EnRA2;

  generate
    for (gi = 0; gi < NPUERTOS; gi++) begin : g_lect
      logic [ANCHO-1:0] w_almacenado;
      assign w_almacenado = (int'(w_ra[gi]) < NREG) ? w_regs[w_ra[gi]] : '0;
`ifdef BANCO_BYPASS_WB_EN
      // Reset masks the bypass so every read port returns 0 while rst is high.
      assign w_rd[gi] = (w_commit && !rst && (w_ra[gi] == EnDirWR)) ? SalDatoWB : w_almacenado;
`else
      assign w_rd[gi] = w_almacenado;
`endif
    end
  endgenerate

  assign SalRD1 = w_rd[0];
  assign SalRD2 = w_rd[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cuenta <= '0;
    end else if (w_commit) begin
      r_cuenta <= r_cuenta + 32'd1;
    end
  end

  assign SalCuentaWB = r_cuenta;

endmodule
